imem_loader: RTL

- Boot-time program loader: the writing end of the instruction memory that the pipelined datapath fetches from.
- Receives a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them to consecutive word addresses from 0. The PC increments by 1, so addresses are word addresses.
- Holds the CPU (cpu_hold) until a complete, checksum-verified image is loaded.

---
 rtl/imem_loader_if.sv | 9 +
 rtl/imem_loader.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream handshake into the instruction memory loader
interface imem_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader assembling big-endian words into instruction memory
module imem_loader #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    imem_loader_if.slave      in_if,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);
    localparam int CW = LEN_W + 1;
    localparam logic [CW-1:0] MAX_WORDS = {{LEN_W{1'b0}}, 1'b1} << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK, S_DONE, S_ERR
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        len_hi_q, len_hi_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       shift_q, shift_d;
    logic [7:0]        csum_q, csum_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              ready_c;
    logic              xfer;
    logic [LEN_W-1:0]  len_rx;
    logic              last_word;

    assign ready_c = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                     (state_q == S_DATA)   || (state_q == S_CHECK);
    assign xfer    = in_if.in_valid && ready_c;
    assign len_rx  = {len_hi_q, in_if.in_data};
    // words_q still lags the word being completed: its write lands next cycle
    assign last_word = ({1'b0, len_q} == (CW'(words_q) + CW'(1)));

    always_comb begin
        state_d    = state_q;
        len_hi_d   = len_hi_q;
        len_d      = len_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        csum_d     = csum_q;
        words_d    = words_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        hold_d     = hold_q;
        done_d     = done_q;
        error_d    = error_q;

        if (we_q) begin
            words_d = words_q + {{ADDR_W{1'b0}}, 1'b1};
        end

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d    = S_LEN_HI;
                    csum_d     = 8'h00;
                    words_d    = '0;
                    byte_cnt_d = 2'd0;
                    error_d    = 1'b0;
                    done_d     = 1'b0;
                    hold_d     = 1'b1;
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    len_hi_d = in_if.in_data;
                    state_d  = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    len_d = len_rx;
                    if ({1'b0, len_rx} > MAX_WORDS) begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end else if (len_rx == '0) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    shift_d    = {shift_q[23:0], in_if.in_data};
                    csum_d     = csum_q ^ in_if.in_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = words_q[ADDR_W-1:0];
                        wdata_d = {shift_q[23:0], in_if.in_data};
                        if (last_word) begin
                            state_d = S_CHECK;
                        end
                    end
                end
            end
            S_CHECK: begin
                if (xfer) begin
                    if (in_if.in_data == csum_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            len_hi_q   <= 8'h00;
            len_q      <= '0;
            byte_cnt_q <= 2'd0;
            shift_q    <= 32'h0;
            csum_q     <= 8'h00;
            words_q    <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            hold_q     <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_hi_q   <= len_hi_d;
            len_q      <= len_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            csum_q     <= csum_d;
            words_q    <= words_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign in_if.in_ready = ready_c;
    assign imem_we        = we_q;
    assign imem_addr      = addr_q;
    assign imem_wdata     = wdata_q;
    assign cpu_hold       = hold_q;
    assign done           = done_q;
    assign error          = error_q;
    assign words_loaded   = words_q;
endmodule
